// File: rtl/eth_rx.sv
// eth_rx: 10BASE-T receive front end; Manchester decode, SFD hunt, byte strobes, frame status.
// Optional CRC checker enabled by defining ETH_RX_CRC_EN; without it rx_crc_ok stays 0.
module eth_rx #(
    parameter int CLK_PER_BIT = 8,
    parameter int MAX_BYTES   = 1518,
    parameter int MIN_BYTES   = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    output logic        rx_sof,
    output logic        rx_eof,
    output logic [10:0] rx_len,
    output logic        rx_crc_ok,
    output logic        rx_err
);
    localparam int SAT = 2 * CLK_PER_BIT;
    localparam int TW  = $clog2(SAT + 1);
    localparam logic [TW-1:0] T_SAT = TW'(SAT);
    localparam logic [TW-1:0] T_MID = TW'(3 * CLK_PER_BIT / 4);
    localparam logic [10:0] L_MAX = 11'(MAX_BYTES);
    localparam logic [10:0] L_MIN = 11'(MIN_BYTES);
    localparam logic [10:0] Q_END = 11'(SAT - 1);

    typedef enum logic [1:0] {QUIET, HUNT, DATA} state_t;

    state_t        state;
    logic [2:0]    sync;
    logic [TW-1:0] t;
    logic          chg, accept, loss, bv, dbit;
    logic [7:0]    sh, nsh;
    logic [2:0]    bc;
    logic [10:0]   cnt;
    logic          crc_ok_now, crc_bad;

    assign chg    = sync[1] ^ sync[2];
    assign accept = chg && (t >= T_MID);
    assign loss   = t == T_SAT;
    assign nsh    = {dbit, sh[7:1]};

    // synchronizer, time-since-accepted-edge timer and mid-bit decoder
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            sync <= '0;
            t    <= T_SAT;
            bv   <= 1'b0;
            dbit <= 1'b0;
        end else begin
            sync <= {sync[1:0], rx};
            t    <= accept ? TW'(1) : loss ? t : t + 1'b1;
            bv   <= accept;
            dbit <= sync[1];
        end

`ifdef ETH_RX_CRC_EN
    localparam logic [31:0] RESIDUE = 32'hC704DD7B;
    logic [31:0] crc, crc_nx;
    logic        ok, data_bit, byte_done, sfd_hit;

    assign data_bit   = (state == DATA) && bv && !loss;
    assign byte_done  = data_bit && (bc == 3'd7);
    assign sfd_hit    = (state == HUNT) && bv && (nsh == 8'hD5);
    assign crc_nx     = {crc[30:0], 1'b0} ^ ({32{dbit ^ crc[31]}} & 32'h04C11DB7);
    assign crc_ok_now = byte_done ? (crc_nx == RESIDUE) : ok;
    assign crc_bad    = ~crc_ok_now;

    // serial CRC over data bits; residue captured only at byte boundaries so dribble bits do not count
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            crc <= '1;
            ok  <= 1'b0;
        end else if (sfd_hit) begin
            crc <= '1;
            ok  <= 1'b0;
        end else if (data_bit) begin
            crc <= crc_nx;
            if (byte_done) ok <= crc_nx == RESIDUE;
        end
`else
    assign crc_ok_now = 1'b0;
    assign crc_bad    = 1'b0;
`endif

    // frame FSM: QUIET waits for an edge-free gap, HUNT looks for SFD, DATA emits bytes and status
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state     <= QUIET;
            sh        <= '0;
            bc        <= '0;
            cnt       <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            rx_sof    <= 1'b0;
            rx_eof    <= 1'b0;
            rx_len    <= '0;
            rx_crc_ok <= 1'b0;
            rx_err    <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            rx_sof   <= 1'b0;
            rx_eof   <= 1'b0;
            case (state)
                QUIET: begin
                    cnt <= chg ? '0 : cnt + 11'd1;
                    if (!chg && cnt == Q_END) state <= HUNT;
                end
                HUNT: begin
                    if (bv) begin
                        sh <= nsh;
                        if (nsh == 8'hD5) begin
                            state <= DATA;
                            bc    <= '0;
                            cnt   <= '0;
                        end
                    end
                end
                DATA: begin
                    if (loss) begin
                        rx_eof    <= 1'b1;
                        rx_len    <= cnt;
                        rx_crc_ok <= crc_ok_now;
                        rx_err    <= (cnt < L_MIN) || crc_bad;
                        state     <= HUNT;
                    end else if (bv) begin
                        sh <= nsh;
                        bc <= bc + 3'd1;
                        if (bc == 3'd7) begin
                            if (cnt == L_MAX) begin
                                rx_eof    <= 1'b1;
                                rx_len    <= cnt + 11'd1;
                                rx_crc_ok <= crc_ok_now;
                                rx_err    <= 1'b1;
                                cnt       <= '0;
                                state     <= QUIET;
                            end else begin
                                rx_valid <= 1'b1;
                                rx_data  <= nsh;
                                rx_sof   <= cnt == '0;
                                cnt      <= cnt + 11'd1;
                            end
                        end
                    end
                end
                default: state <= QUIET;
            endcase
        end
endmodule

// File: tb/tb_eth_rx.sv
// tb_eth_rx: directed Manchester frames into eth_rx; byte stream and end-of-frame status checked.
// Expected crc_ok/err follow ETH_RX_CRC_EN when it is defined for the build.
module tb_eth_rx;
    localparam int CPB  = 8;
    localparam int MAXB = 100;
    localparam int MINB = 64;
`ifdef ETH_RX_CRC_EN
    localparam logic CRC_EN = 1'b1;
`else
    localparam logic CRC_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx  = 1'b0;
    logic [7:0]  rx_data;
    logic        rx_valid, rx_sof, rx_eof, rx_crc_ok, rx_err;
    logic [10:0] rx_len;

    eth_rx #(.CLK_PER_BIT(CPB), .MAX_BYTES(MAXB), .MIN_BYTES(MINB)) dut (
        .clk(clk), .rst(rst), .rx(rx), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_sof(rx_sof), .rx_eof(rx_eof), .rx_len(rx_len), .rx_crc_ok(rx_crc_ok), .rx_err(rx_err)
    );

    always #5 clk = ~clk;

    int          checks = 0, errors = 0;
    logic [7:0]  got [8192];
    int          nv = 0, nsof = 0, sof_pos = -1, neof = 0, ncoin = 0;
    logic [10:0] elen = '0;
    logic        eerr = 1'b0, eok = 1'b0;
    logic [7:0]  frm [256];
    int          jit = 0;

    // monitor: record every byte strobe and the status of every end-of-frame
    always @(negedge clk) begin
        if (rx_valid) begin
            if (nv < 8192) got[nv] = rx_data;
            if (rx_sof) begin nsof++; sof_pos = nv; end
            nv++;
        end
        if (rx_eof) begin neof++; elen = rx_len; eerr = rx_err; eok = rx_crc_ok; end
        if (rx_valid && rx_eof) ncoin++;
    end

    function automatic logic [31:0] crc_step(input logic [31:0] c, input logic d);
        return {c[30:0], 1'b0} ^ ({32{d ^ c[31]}} & 32'h04C11DB7);
    endfunction

    task automatic build(input int n, input int fb, input int fi);
        logic [31:0] c;
        c = '1;
        for (int i = 0; i < n - 4; i++) begin
            frm[i] = 8'(i * 37 + 11);
            for (int k = 0; k < 8; k++) c = crc_step(c, frm[i][k]);
        end
        for (int k = 0; k < 4; k++)
            for (int i = 0; i < 8; i++) frm[n-4+k][i] = ~c[31-8*k-i];
        if (fb >= 0) frm[fb][fi] = ~frm[fb][fi];
    endtask

    // one bit cell: first half ~b, second half b; the mid edge wanders by -1/0/+1 clk
    task automatic send_bit(input logic b);
        int j;
        j = (jit % 3) - 1;
        jit++;
        rx = ~b;
        repeat (4 + j) @(negedge clk);
        rx = b;
        repeat (4 - j) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 0; i < 8; i++) send_bit(v[i]);
    endtask

    task automatic send_pre();
        for (int i = 0; i < 7; i++) send_byte(8'h55);
        send_byte(8'hD5);
    endtask

    task automatic send_bytes(input int first, input int last);
        for (int i = first; i < last; i++) send_byte(frm[i]);
    endtask

    task automatic finish_frame(input int dribble);
        for (int i = 0; i < dribble; i++) send_bit(i % 2 == 0);
        rx = 1'b0;
        repeat (40) @(negedge clk);
    endtask

    task automatic test_reset();
        int b0, e0;
        rst = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            rx = ~rx;
        end
        checks++;
        if ({rx_data, rx_valid, rx_sof, rx_eof, rx_len, rx_crc_ok, rx_err} !== 24'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h want 0", {rx_data, rx_valid, rx_sof, rx_eof, rx_len, rx_crc_ok, rx_err});
        end
        rx = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        b0 = nv;
        e0 = neof;
        for (int i = 0; i < 24; i++) send_byte(8'h55);
        finish_frame(0);
        checks++;
        if (nv - b0 !== 0) begin errors++; $display("FAIL no_sfd_strobes: got %0d want 0", nv - b0); end
        checks++;
        if (neof - e0 !== 0) begin errors++; $display("FAIL no_sfd_eof: got %0d want 0", neof - e0); end
    endtask

    task automatic test_good_frame();
        int b0, e0, s0, bad;
        build(64, -1, 0);
        b0 = nv; e0 = neof; s0 = nsof;
        send_pre();
        send_bytes(0, 64);
        finish_frame(0);
        checks++;
        if (nv - b0 !== 64) begin errors++; $display("FAIL good_count: got %0d want 64", nv - b0); end
        bad = 0;
        for (int i = 0; i < 64; i++) if (got[b0+i] !== frm[i]) bad++;
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL good_bytes: got %0d wrong bytes want 0", bad); end
        checks++;
        if (nsof - s0 !== 1 || sof_pos !== b0) begin
            errors++; $display("FAIL good_sof: got %0d sofs at %0d want 1 at %0d", nsof - s0, sof_pos, b0);
        end
        checks++;
        if (neof - e0 !== 1) begin errors++; $display("FAIL good_eof: got %0d want 1", neof - e0); end
        checks++;
        if (elen !== 11'd64) begin errors++; $display("FAIL good_len: got %0d want 64", elen); end
        checks++;
        if (eok !== CRC_EN) begin errors++; $display("FAIL good_crc_ok: got %0d want %0d", eok, CRC_EN); end
        checks++;
        if (eerr !== 1'b0) begin errors++; $display("FAIL good_err: got %0d want 0", eerr); end
    endtask

    task automatic test_bad_crc();
        int b0, e0;
        build(64, 10, 3);
        b0 = nv; e0 = neof;
        send_pre();
        send_bytes(0, 64);
        finish_frame(0);
        checks++;
        if (nv - b0 !== 64) begin errors++; $display("FAIL badcrc_count: got %0d want 64", nv - b0); end
        checks++;
        if (got[b0+10] !== frm[10]) begin errors++; $display("FAIL badcrc_byte10: got %h want %h", got[b0+10], frm[10]); end
        checks++;
        if (neof - e0 !== 1 || elen !== 11'd64) begin
            errors++; $display("FAIL badcrc_eof: got %0d eofs len %0d want 1 len 64", neof - e0, elen);
        end
        checks++;
        if (eok !== 1'b0) begin errors++; $display("FAIL badcrc_crc_ok: got %0d want 0", eok); end
        checks++;
        if (eerr !== CRC_EN) begin errors++; $display("FAIL badcrc_err: got %0d want %0d", eerr, CRC_EN); end
    endtask

    task automatic test_short_dribble();
        int b0, e0;
        build(40, -1, 0);
        b0 = nv; e0 = neof;
        send_pre();
        send_bytes(0, 40);
        finish_frame(3);
        checks++;
        if (nv - b0 !== 40) begin errors++; $display("FAIL short_count: got %0d want 40", nv - b0); end
        checks++;
        if (neof - e0 !== 1) begin errors++; $display("FAIL short_eof: got %0d want 1", neof - e0); end
        checks++;
        if (elen !== 11'd40) begin errors++; $display("FAIL short_len: got %0d want 40", elen); end
        checks++;
        if (eerr !== 1'b1) begin errors++; $display("FAIL short_err: got %0d want 1", eerr); end
        checks++;
        if (eok !== CRC_EN) begin errors++; $display("FAIL short_crc_ok: got %0d want %0d", eok, CRC_EN); end
    endtask

    task automatic test_oversize();
        int b0, e0, bad;
        build(MAXB + 30, -1, 0);
        b0 = nv; e0 = neof;
        send_pre();
        send_bytes(0, MAXB + 30);
        finish_frame(0);
        checks++;
        if (nv - b0 !== MAXB) begin errors++; $display("FAIL over_count: got %0d want %0d", nv - b0, MAXB); end
        bad = 0;
        for (int i = 0; i < MAXB; i++) if (got[b0+i] !== frm[i]) bad++;
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL over_bytes: got %0d wrong bytes want 0", bad); end
        checks++;
        if (neof - e0 !== 1) begin errors++; $display("FAIL over_eof: got %0d want 1", neof - e0); end
        checks++;
        if (elen !== 11'(MAXB + 1)) begin errors++; $display("FAIL over_len: got %0d want %0d", elen, MAXB + 1); end
        checks++;
        if (eerr !== 1'b1) begin errors++; $display("FAIL over_err: got %0d want 1", eerr); end
        build(64, -1, 0);
        b0 = nv; e0 = neof;
        send_pre();
        send_bytes(0, 64);
        finish_frame(0);
        checks++;
        if (nv - b0 !== 64 || neof - e0 !== 1) begin
            errors++; $display("FAIL after_over_frame: got %0d bytes %0d eofs want 64 1", nv - b0, neof - e0);
        end
        checks++;
        if (elen !== 11'd64 || eerr !== 1'b0) begin
            errors++; $display("FAIL after_over_status: got len %0d err %0d want 64 0", elen, eerr);
        end
    endtask

    task automatic test_reset_mid();
        int b0, e0, bad;
        build(64, -1, 0);
        e0 = neof;
        send_pre();
        send_bytes(0, 20);
        rst = 1'b1;
        #2;
        checks++;
        if ({rx_data, rx_valid, rx_sof, rx_eof, rx_len, rx_crc_ok, rx_err} !== 24'd0) begin
            errors++;
            $display("FAIL midrst_outputs: got %h want 0", {rx_data, rx_valid, rx_sof, rx_eof, rx_len, rx_crc_ok, rx_err});
        end
        @(negedge clk);
        rst = 1'b0;
        b0 = nv;
        send_bytes(20, 64);
        finish_frame(0);
        checks++;
        if (nv - b0 !== 0) begin errors++; $display("FAIL midrst_strobes: got %0d want 0", nv - b0); end
        checks++;
        if (neof - e0 !== 0) begin errors++; $display("FAIL midrst_eof: got %0d want 0", neof - e0); end
        build(64, -1, 0);
        b0 = nv; e0 = neof;
        send_pre();
        send_bytes(0, 64);
        finish_frame(0);
        bad = 0;
        for (int i = 0; i < 64; i++) if (got[b0+i] !== frm[i]) bad++;
        checks++;
        if (nv - b0 !== 64 || bad !== 0) begin
            errors++; $display("FAIL midrst_next_bytes: got %0d bytes %0d wrong want 64 0", nv - b0, bad);
        end
        checks++;
        if (neof - e0 !== 1 || elen !== 11'd64 || eerr !== 1'b0 || eok !== CRC_EN) begin
            errors++;
            $display("FAIL midrst_next_status: got eofs %0d len %0d err %0d ok %0d want 1 64 0 %0d", neof - e0, elen, eerr, eok, CRC_EN);
        end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_bad_crc();
        test_short_dribble();
        test_oversize();
        test_reset_mid();
        checks++;
        if (ncoin !== 0) begin errors++; $display("FAIL valid_eof_overlap: got %0d want 0", ncoin); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
